// File: rtl/regfile_param.sv
// Parametrised register file: 2 combinational read ports, 1 clocked write port, sequential clear engine.
// Latency: reads 0 cycles (optional same-cycle write bypass); write visible next cycle; ack/drop pulses 1 cycle after request.
// Backpressure: busy is high for exactly DEPTH cycles during a clear; writes arriving while busy are refused and flagged on write_drop.
module regfile_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_register1,
    input  logic [ADDR_W-1:0] read_register2,
    input  logic [ADDR_W-1:0] write_register,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              clear_req,
    output logic              busy,
    output logic              write_now,
    output logic              write_drop,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_write_now;
    logic              r_write_drop;

    logic              w_busy;
    logic              w_zero_hit;
    logic              w_accept;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // busy is the CLEAR state itself, so it rises on the edge that starts the sweep
    assign w_busy = (r_state == ST_CLEAR);

    // Entry 0 is hardwired to zero when ZERO_REG0 is set: such writes are silently ignored
    assign w_zero_hit = (ZERO_REG0 != 0) && (write_register == '0);
    assign w_accept   = reg_write && !w_busy && !w_zero_hit;

    // State and sweep pointer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic: a clear request only starts a sweep from IDLE; one sweep visits every entry once
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Storage: the sweep and accepted writes are mutually exclusive because accept requires !busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_busy) begin
            r_mem[r_ptr] <= '0;
        end else if (w_accept) begin
            r_mem[write_register] <= write_data;
        end
    end

    // Registered one-cycle acknowledge / refusal pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write_now  <= 1'b0;
            r_write_drop <= 1'b0;
        end else begin
            r_write_now  <= w_accept;
            r_write_drop <= reg_write && w_busy;
        end
    end

    // Read port 1: array lookup, then bypass, then the hardwired-zero override wins over both
    always_comb begin
        w_rd1 = r_mem[read_register1];
        if ((BYPASS != 0) && w_accept && (read_register1 == write_register)) begin
            w_rd1 = write_data;
        end
        if ((ZERO_REG0 != 0) && (read_register1 == '0)) begin
            w_rd1 = '0;
        end
    end

    // Read port 2: resolved independently of port 1
    always_comb begin
        w_rd2 = r_mem[read_register2];
        if ((BYPASS != 0) && w_accept && (read_register2 == write_register)) begin
            w_rd2 = write_data;
        end
        if ((ZERO_REG0 != 0) && (read_register2 == '0)) begin
            w_rd2 = '0;
        end
    end

    assign read_data1 = w_rd1;
    assign read_data2 = w_rd2;
    // Debug tap shows stored contents only; entry 0 stays 0 under ZERO_REG0 since it is never written
    assign dbg_data   = r_mem[dbg_addr];
    assign busy       = w_busy;
    assign write_now  = r_write_now;
    assign write_drop = r_write_drop;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three instances (default, hardwired zero, 16x16).
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and compares.
// Inputs driven 1 time unit after the rising edge.
module tb_regfile_param;

    logic clk;
    logic rst_n;
    int   cyc;

    // u0: DATA_W=8 ADDR_W=2 BYPASS=1 ZERO_REG0=0
    logic [1:0] a_rr1, a_rr2, a_wr, a_dbg;
    logic       a_we, a_clr;
    logic [7:0] a_wd, a_rd1, a_rd2, a_dd;
    logic       a_busy, a_wnow, a_wdrop;
    // u1: DATA_W=8 ADDR_W=2 BYPASS=1 ZERO_REG0=1
    logic [1:0] z_rr1, z_rr2, z_wr, z_dbg;
    logic       z_we, z_clr;
    logic [7:0] z_wd, z_rd1, z_rd2, z_dd;
    logic       z_busy, z_wnow, z_wdrop;
    // u2: DATA_W=16 ADDR_W=4
    logic [3:0]  b_rr1, b_rr2, b_wr, b_dbg;
    logic        b_we, b_clr;
    logic [15:0] b_wd, b_rd1, b_rd2, b_dd;
    logic        b_busy, b_wnow, b_wdrop;

    regfile_param #(.DATA_W(8), .ADDR_W(2), .BYPASS(1), .ZERO_REG0(0)) u0 (
        .clk(clk), .reset(rst_n),
        .read_register1(a_rr1), .read_register2(a_rr2), .write_register(a_wr),
        .reg_write(a_we), .write_data(a_wd), .read_data1(a_rd1), .read_data2(a_rd2),
        .clear_req(a_clr), .busy(a_busy), .write_now(a_wnow), .write_drop(a_wdrop),
        .dbg_addr(a_dbg), .dbg_data(a_dd));

    regfile_param #(.DATA_W(8), .ADDR_W(2), .BYPASS(1), .ZERO_REG0(1)) u1 (
        .clk(clk), .reset(rst_n),
        .read_register1(z_rr1), .read_register2(z_rr2), .write_register(z_wr),
        .reg_write(z_we), .write_data(z_wd), .read_data1(z_rd1), .read_data2(z_rd2),
        .clear_req(z_clr), .busy(z_busy), .write_now(z_wnow), .write_drop(z_wdrop),
        .dbg_addr(z_dbg), .dbg_data(z_dd));

    regfile_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG0(0)) u2 (
        .clk(clk), .reset(rst_n),
        .read_register1(b_rr1), .read_register2(b_rr2), .write_register(b_wr),
        .reg_write(b_we), .write_data(b_wd), .read_data1(b_rd1), .read_data2(b_rd2),
        .clear_req(b_clr), .busy(b_busy), .write_now(b_wnow), .write_drop(b_wdrop),
        .dbg_addr(b_dbg), .dbg_data(b_dd));

    localparam int A_RD1 = 0,  A_RD2 = 1,  A_DBG = 2,  A_BUSY = 3,  A_WNOW = 4,  A_WDROP = 5;
    localparam int Z_RD1 = 10, Z_RD2 = 11, Z_DBG = 12, Z_BUSY = 13, Z_WNOW = 14, Z_WDROP = 15;
    localparam int B_RD1 = 20, B_RD2 = 21, B_DBG = 22, B_BUSY = 23, B_WNOW = 24, B_WDROP = 25;

    typedef struct {
        int          at;
        int          sig;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] get_val(input int sig);
        case (sig)
            A_RD1:   return {8'h00, a_rd1};
            A_RD2:   return {8'h00, a_rd2};
            A_DBG:   return {8'h00, a_dd};
            A_BUSY:  return {15'h0, a_busy};
            A_WNOW:  return {15'h0, a_wnow};
            A_WDROP: return {15'h0, a_wdrop};
            Z_RD1:   return {8'h00, z_rd1};
            Z_RD2:   return {8'h00, z_rd2};
            Z_DBG:   return {8'h00, z_dd};
            Z_BUSY:  return {15'h0, z_busy};
            Z_WNOW:  return {15'h0, z_wnow};
            Z_WDROP: return {15'h0, z_wdrop};
            B_RD1:   return b_rd1;
            B_RD2:   return b_rd2;
            B_DBG:   return b_dd;
            B_BUSY:  return {15'h0, b_busy};
            B_WNOW:  return {15'h0, b_wnow};
            B_WDROP: return {15'h0, b_wdrop};
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: compare every expectation stamped for this cycle; anything older was missed
    always @(negedge clk) begin
        chk_t        keep[$];
        logic [15:0] got;
        keep = {};
        foreach (q[i]) begin
            if (q[i].at == cyc) begin
                got = get_val(q[i].sig);
                n_checks++;
                if (got !== q[i].exp) begin
                    n_errors++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", q[i].name, cyc, got, q[i].exp);
                end
            end else if (q[i].at < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s stale cyc=%0d stamped=%0d got=none want=%h", q[i].name, cyc, q[i].at, q[i].exp);
            end else begin
                keep.push_back(q[i]);
            end
        end
        q = keep;
    end

    task automatic ex(input int d, input int sig, input logic [15:0] v, input string n);
        chk_t c;
        c.at   = cyc + d;
        c.sig  = sig;
        c.exp  = v;
        c.name = n;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_rr1 = '0; a_rr2 = '0; a_wr = '0; a_dbg = '0; a_we = 1'b0; a_clr = 1'b0; a_wd = '0;
        z_rr1 = '0; z_rr2 = '0; z_wr = '0; z_dbg = '0; z_we = 1'b0; z_clr = 1'b0; z_wd = '0;
        b_rr1 = '0; b_rr2 = '0; b_wr = '0; b_dbg = '0; b_we = 1'b0; b_clr = 1'b0; b_wd = '0;

        // ---- reset state
        tick();
        ex(0, A_BUSY, 16'h0, "rst_busy");
        ex(0, A_WNOW, 16'h0, "rst_wnow");
        ex(0, A_WDROP, 16'h0, "rst_wdrop");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_rr1 = 2'(i); a_rr2 = 2'(3 - i); a_dbg = 2'(i);
            ex(0, A_RD1, 16'h0, "rst_rd1");
            ex(0, A_RD2, 16'h0, "rst_rd2");
            ex(0, A_DBG, 16'h0, "rst_dbg");
            ex(0, A_BUSY, 16'h0, "rst_busy_run");
            ex(0, A_WNOW, 16'h0, "rst_wnow_run");
            tick();
        end

        // ---- write A5 to reg 2 with same-cycle bypass
        a_we = 1'b1; a_wr = 2'd2; a_wd = 8'hA5; a_rr1 = 2'd2; a_rr2 = 2'd1;
        ex(0, A_RD1, 16'h00A5, "byp_rd1");
        ex(0, A_RD2, 16'h0000, "byp_rd2_other");
        ex(1, A_WNOW, 16'h1, "wnow_pulse");
        ex(1, A_WDROP, 16'h0, "wdrop_quiet");
        tick();
        a_we = 1'b0; a_dbg = 2'd2; a_rr1 = 2'd2;
        ex(0, A_DBG, 16'h00A5, "dbg_after_wr");
        ex(0, A_RD1, 16'h00A5, "rd1_stored");
        ex(1, A_WNOW, 16'h0, "wnow_single");
        tick();
        // both ports on the write address
        a_we = 1'b1; a_wr = 2'd1; a_wd = 8'h3C; a_rr1 = 2'd1; a_rr2 = 2'd1; a_dbg = 2'd1;
        ex(0, A_RD1, 16'h003C, "byp_both1");
        ex(0, A_RD2, 16'h003C, "byp_both2");
        ex(0, A_DBG, 16'h0000, "dbg_no_bypass");
        tick();
        a_we = 1'b0;

        // ---- load 11,22,33,44 then clear sweep
        for (int i = 0; i < 4; i++) begin
            a_we = 1'b1; a_wr = 2'(i); a_wd = 8'(8'h11 * (i + 1));
            tick();
        end
        a_we = 1'b0;
        a_clr = 1'b1;
        ex(0, A_BUSY, 16'h0, "clr_busy_pre");
        tick();
        a_clr = 1'b0; a_rr1 = 2'd0; a_rr2 = 2'd3;
        ex(0, A_BUSY, 16'h1, "clr_busy_c1");
        ex(0, A_RD1, 16'h0011, "clr_c1_rd0_old");
        ex(0, A_RD2, 16'h0044, "clr_c1_rd3_old");
        tick();
        a_we = 1'b1; a_wr = 2'd1; a_wd = 8'h77; a_rr1 = 2'd1; a_rr2 = 2'd0;
        ex(0, A_BUSY, 16'h1, "clr_busy_c2");
        ex(0, A_RD1, 16'h0022, "clr_c2_no_bypass");
        ex(0, A_RD2, 16'h0000, "clr_c2_rd0_cleared");
        ex(1, A_WDROP, 16'h1, "wdrop_pulse");
        ex(1, A_WNOW, 16'h0, "wnow_not_on_drop");
        tick();
        a_we = 1'b0; a_rr1 = 2'd1; a_rr2 = 2'd3;
        ex(0, A_BUSY, 16'h1, "clr_busy_c3");
        ex(0, A_RD1, 16'h0000, "clr_c3_rd1_cleared");
        ex(0, A_RD2, 16'h0044, "clr_c3_rd3_old");
        tick();
        a_rr1 = 2'd3; a_rr2 = 2'd2;
        ex(0, A_BUSY, 16'h1, "clr_busy_c4");
        ex(0, A_RD1, 16'h0044, "clr_c4_rd3_old");
        ex(0, A_RD2, 16'h0000, "clr_c4_rd2_cleared");
        ex(0, A_WDROP, 16'h0, "wdrop_single");
        tick();
        ex(0, A_BUSY, 16'h0, "clr_busy_done");
        for (int i = 0; i < 4; i++) begin
            a_rr1 = 2'(i); a_dbg = 2'(i);
            ex(0, A_RD1, 16'h0, "clr_after_rd");
            ex(0, A_DBG, 16'h0, "clr_after_dbg");
            tick();
        end

        // ---- simultaneous clear_req and write in IDLE
        a_we = 1'b1; a_wr = 2'd3; a_wd = 8'h5A; a_clr = 1'b1; a_rr1 = 2'd3; a_dbg = 2'd3;
        ex(0, A_BUSY, 16'h0, "sim_busy0");
        ex(0, A_RD1, 16'h005A, "sim_bypass");
        ex(1, A_WNOW, 16'h1, "sim_wnow");
        tick();
        a_we = 1'b0; a_clr = 1'b0;
        ex(0, A_DBG, 16'h005A, "sim_stored");
        for (int i = 0; i < 4; i++) begin
            ex(i, A_BUSY, 16'h1, "sim_busy_run");
        end
        ex(4, A_BUSY, 16'h0, "sim_busy_end");
        ex(4, A_DBG, 16'h0, "sim_reg3_cleared");
        repeat (4) tick();
        tick();

        // ---- reset in the middle of a sweep
        for (int i = 0; i < 4; i++) begin
            a_we = 1'b1; a_wr = 2'(i); a_wd = 8'(i + 1);
            tick();
        end
        a_we = 1'b0;
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        ex(0, A_BUSY, 16'h1, "mid_busy_c1");
        tick();
        rst_n = 1'b0;
        a_rr1 = 2'd1; a_rr2 = 2'd2; a_dbg = 2'd3;
        ex(0, A_BUSY, 16'h0, "mid_rst_busy");
        ex(0, A_RD1, 16'h0, "mid_rst_rd1");
        ex(0, A_RD2, 16'h0, "mid_rst_rd2");
        ex(0, A_DBG, 16'h0, "mid_rst_dbg");
        tick();
        rst_n = 1'b1;
        tick();
        a_clr = 1'b1;
        ex(0, A_BUSY, 16'h0, "fresh_busy_pre");
        tick();
        a_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex(i, A_BUSY, 16'h1, "fresh_busy_run");
        end
        ex(4, A_BUSY, 16'h0, "fresh_busy_end");
        repeat (5) tick();

        // ---- hardwired zero entry
        z_we = 1'b1; z_wr = 2'd0; z_wd = 8'hFF; z_rr1 = 2'd0; z_rr2 = 2'd0;
        ex(0, Z_RD1, 16'h0, "z0_rd1_same");
        ex(0, Z_RD2, 16'h0, "z0_rd2_same");
        ex(1, Z_WNOW, 16'h0, "z0_no_wnow");
        ex(1, Z_WDROP, 16'h0, "z0_no_wdrop");
        tick();
        z_we = 1'b0; z_dbg = 2'd0;
        ex(0, Z_RD1, 16'h0, "z0_rd1_next");
        ex(0, Z_DBG, 16'h0, "z0_dbg_next");
        tick();
        z_we = 1'b1; z_wr = 2'd1; z_wd = 8'h3C; z_rr1 = 2'd1;
        ex(0, Z_RD1, 16'h003C, "z1_bypass");
        ex(1, Z_WNOW, 16'h1, "z1_wnow");
        tick();
        z_we = 1'b0;
        tick();

        // ---- 16-bit x 16-entry instance
        b_we = 1'b1; b_wr = 4'd15; b_wd = 16'hBEEF;
        ex(1, B_WNOW, 16'h1, "w_wnow");
        tick();
        b_we = 1'b1; b_wr = 4'd0; b_wd = 16'h1234; b_rr1 = 4'd15;
        ex(0, B_RD1, 16'hBEEF, "w_rd15");
        tick();
        b_we = 1'b0; b_dbg = 4'd0; b_clr = 1'b1;
        ex(0, B_DBG, 16'h1234, "w_dbg0");
        ex(0, B_BUSY, 16'h0, "w_busy_pre");
        tick();
        b_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ex(i, B_BUSY, 16'h1, "w_busy_run");
        end
        ex(16, B_BUSY, 16'h0, "w_busy_end");
        ex(16, B_RD1, 16'h0, "w_rd15_cleared");
        ex(16, B_DBG, 16'h0, "w_dbg0_cleared");
        repeat (17) tick();

        repeat (3) tick();
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
